// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: size codes, FSM states,
// access legality checking and store lane enables.
package mem_pkg;

    // funct3 size codes as seen on the load/store port
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // True when the access must complete with FAULT: illegal size for the
    // direction, natural misalignment, or a word index beyond the array.
    function automatic logic access_fault(
        input logic        we,
        input logic [2:0]  size,
        input logic [31:0] addr,
        input int unsigned depth_words
    );
        logic legal;
        logic misaligned;
        logic out_of_range;
        case (size)
            SZ_B, SZ_H, SZ_W: legal = 1'b1;
            SZ_BU, SZ_HU:     legal = !we;
            default:          legal = 1'b0;
        endcase
        misaligned   = ((size[1:0] == 2'b01) && addr[0]) ||
                       ((size[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        out_of_range = {2'b00, addr[31:2]} >= depth_words;
        return !legal || misaligned || out_of_range;
    endfunction

    // Byte lanes touched by a (legal) store of the given width and offset.
    function automatic logic [3:0] lane_enables(
        input logic [1:0] size_lo,
        input logic [1:0] addr_lo
    );
        case (size_lo)
            2'b00:   return 4'b0001 << addr_lo;
            2'b01:   return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half from a little-endian 32-bit word and
// sign- or zero-extends it according to the funct3 size code.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension; word and unknown codes pass through
    // NOTE: every output of an always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    result = {{24{byte_sel[7]}}, byte_sel};
            SZ_BU:   result = {24'd0, byte_sel};
            SZ_H:    result = {{16{half_sel[15]}}, half_sel};
            SZ_HU:   result = {16'd0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store port. Captures a request in
// IDLE, spends WAIT_STATES cycles in WAIT, then pulses READY for one cycle in
// RESP with registered, extended load data and a FAULT flag.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        WE,
    input  logic [2:0]  SIZE,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic [31:0] RDATA,
    output logic        READY,
    output logic        FAULT
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam bit          NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0]  WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic [31:0] mem [0:DEPTH_WORDS-1];

    // The access being completed. With no wait states the commit happens on
    // the capture edge itself, so the live request is used directly.
    logic             act_we;
    logic [2:0]       act_size;
    logic [31:0]      act_addr;
    logic [31:0]      act_wdata;
    logic [IDX_W-1:0] act_idx;
    logic             fault_act;
    logic [31:0]      rd_word;
    logic [31:0]      load_ext;
    logic [3:0]       lane_en;
    logic [31:0]      store_lanes;
    logic             enter_resp;
    logic             store_commit;

    assign act_we    = NO_WAIT ? WE    : we_q;
    assign act_size  = NO_WAIT ? SIZE  : size_q;
    assign act_addr  = NO_WAIT ? ADDR  : addr_q;
    assign act_wdata = NO_WAIT ? WDATA : wdata_q;
    assign act_idx   = act_addr[IDX_W+1:2];
    assign fault_act = access_fault(act_we, act_size, act_addr, DEPTH_WORDS);
    assign rd_word   = mem[act_idx];

    load_extend u_load_extend (
        .word    (rd_word),
        .addr_lo (act_addr[1:0]),
        .size    (act_size),
        .result  (load_ext)
    );

    // FSM next state and request capture; REQ only matters in IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (REQ) begin
                    we_d    = WE;
                    size_d  = SIZE;
                    addr_d  = ADDR;
                    wdata_d = WDATA;
                    if (!NO_WAIT) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Completion datapath: store lane steering and result/fault capture on RESP entry
    always_comb begin
        lane_en = lane_enables(act_size[1:0], act_addr[1:0]);
        case (act_size[1:0])
            2'b00:   store_lanes = {4{act_wdata[7:0]}};
            2'b01:   store_lanes = {2{act_wdata[15:0]}};
            default: store_lanes = act_wdata;
        endcase
        enter_resp   = (state_q != RESP) && (state_d == RESP);
        // A reset on the would-be commit edge aborts the access entirely.
        store_commit = enter_resp && RST && act_we && !fault_act;
        rdata_d      = rdata_q;
        fault_d      = fault_q;
        if (enter_resp) begin
            fault_d = fault_act;
            if (!act_we) rdata_d = fault_act ? 32'd0 : load_ext;
        end
    end

    // State, captured request and result registers with synchronous reset
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Lane-masked store commit on the edge entering RESP
    // NOTE: the storage array is deliberately left out of reset; its contents survive RST.
    always_ff @(posedge CLK) begin
        if (store_commit) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (lane_en[lane]) mem[act_idx][8*lane +: 8] <= store_lanes[8*lane +: 8];
            end
        end
    end

    assign READY = (state_q == RESP);
    assign FAULT = READY && fault_q;
    assign RDATA = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: two instances (2 and 0 wait
// states) driven by directed and random accesses, checked against a
// byte-addressed reference memory.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WS_A  = 2;
    localparam int unsigned WS_B  = 0;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SBU = 3'b100;
    localparam logic [2:0] SHU = 3'b101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_a, we_a, ready_a, fault_a;
    logic [2:0]  size_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        req_b, we_b, ready_b, fault_b;
    logic [2:0]  size_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_A)) dut_a (
        .CLK(clk), .RST(rst), .REQ(req_a), .WE(we_a), .SIZE(size_a), .ADDR(addr_a),
        .WDATA(wdata_a), .RDATA(rdata_a), .READY(ready_a), .FAULT(fault_a)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_B)) dut_b (
        .CLK(clk), .RST(rst), .REQ(req_b), .WE(we_b), .SIZE(size_b), .ADDR(addr_b),
        .WDATA(wdata_b), .RDATA(rdata_b), .READY(ready_b), .FAULT(fault_b)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        bit          fault;
        logic [31:0] rdata;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: byte-addressed memory per instance, plus last load result
    logic [7:0]  bmem [longint unsigned];
    logic [31:0] last_rd [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint unsigned key(input int d, input logic [31:0] a);
        return {31'd0, 1'(d), a};
    endfunction

    function automatic void predict(input int d, input bit we, input logic [2:0] size,
                                    input logic [31:0] addr, input logic [31:0] wdata,
                                    output bit fault, output logic [31:0] rd);
        int          nb;
        bit          legal;
        logic [31:0] v;
        legal = we ? (size inside {SB, SH, SW}) : (size inside {SB, SH, SW, SBU, SHU});
        nb    = (size[1:0] == 2'b00) ? 1 : (size[1:0] == 2'b01) ? 2 : 4;
        fault = !legal || ((addr % nb) != 0) || ((addr >> 2) >= DEPTH);
        if (we) begin
            if (!fault)
                for (int b = 0; b < nb; b++) bmem[key(d, addr + 32'(b))] = wdata[8*b +: 8];
        end else if (fault) begin
            last_rd[d] = 32'd0;
        end else begin
            v = 32'd0;
            for (int b = 0; b < nb; b++) v = v | (32'(bmem[key(d, addr + 32'(b))]) << (8*b));
            if (!size[2] && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
            last_rd[d] = v;
        end
        rd = last_rd[d];
    endfunction

    task automatic drive(input int d, input bit r, input bit w, input logic [2:0] s,
                         input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            req_a = r; we_a = w; size_a = s; addr_a = a; wdata_a = wd;
        end else begin
            req_b = r; we_b = w; size_b = s; addr_b = a; wdata_b = wd;
        end
    endtask

    // One request at minimum spacing; inputs are scrambled right after capture
    task automatic access(input int d, input bit we, input logic [2:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        bit          f;
        logic [31:0] r;
        int unsigned ws;
        ws = (d == 0) ? WS_A : WS_B;
        @(negedge clk);
        drive(d, 1'b1, we, size, addr, wdata);
        @(posedge clk);
        #1;
        predict(d, we, size, addr, wdata, f, r);
        e.cyc = cyc + ws; e.fault = f; e.rdata = r;
        if (d == 0) q_a.push_back(e); else q_b.push_back(e);
        drive(d, 1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom);
        repeat (ws + 1) @(posedge clk);
        #1;
    endtask

    // Monitors: pop and compare whenever READY is seen
    always @(negedge clk) begin
        if (ready_a) begin
            exp_t e;
            if (q_a.size() == 0) check("unexpected_ready_a", 32'd1, 32'd0);
            else begin
                e = q_a.pop_front();
                check("ready_cycle_a", cyc, e.cyc);
                check("fault_a", 32'(fault_a), 32'(e.fault));
                check("rdata_a", rdata_a, e.rdata);
            end
        end
    end

    always @(negedge clk) begin
        if (ready_b) begin
            exp_t e;
            if (q_b.size() == 0) check("unexpected_ready_b", 32'd1, 32'd0);
            else begin
                e = q_b.pop_front();
                check("ready_cycle_b", cyc, e.cyc);
                check("fault_b", 32'(fault_b), 32'(e.fault));
                check("rdata_b", rdata_b, e.rdata);
            end
        end
    end

    initial begin
        logic [2:0]  legal_codes [5];
        exp_t        e;
        bit          f;
        logic [31:0] r;
        bit          we;
        logic [2:0]  sz;
        logic [31:0] addr;

        legal_codes = '{SB, SH, SW, SBU, SHU};
        last_rd[0]  = 32'd0;
        last_rd[1]  = 32'd0;
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, SB, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, SB, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("rst_ready_a", 32'(ready_a), 32'd0);
        check("rst_fault_a", 32'(fault_a), 32'd0);
        check("rst_rdata_a", rdata_a, 32'd0);
        check("rst_ready_b", 32'(ready_b), 32'd0);
        check("rst_rdata_b", rdata_b, 32'd0);

        // Fill a 16-word window so every later load reads known contents
        for (int w = 0; w < 16; w++) access(0, 1'b1, SW, 32'(4*w), $urandom);

        // Directed sequence
        access(0, 1'b1, SW, 32'h10, 32'hDEADBEEF);
        access(0, 1'b0, SW, 32'h10, 32'd0);
        check("plan_lw_10", rdata_a, 32'hDEADBEEF);
        access(0, 1'b0, SB, 32'h13, 32'd0);
        check("plan_lb_13", rdata_a, 32'hFFFFFFDE);
        access(0, 1'b0, SBU, 32'h13, 32'd0);
        check("plan_lbu_13", rdata_a, 32'h000000DE);
        access(0, 1'b0, SH, 32'h10, 32'd0);
        check("plan_lh_10", rdata_a, 32'hFFFFBEEF);
        access(0, 1'b0, SHU, 32'h12, 32'd0);
        check("plan_lhu_12", rdata_a, 32'h0000DEAD);
        access(0, 1'b1, SB, 32'h11, 32'hAABBCC55);
        access(0, 1'b0, SW, 32'h10, 32'd0);
        check("plan_sb_lw_10", rdata_a, 32'hDEAD55EF);
        access(0, 1'b0, SW, 32'h12, 32'd0);
        check("plan_misaligned_rdata", rdata_a, 32'd0);
        access(0, 1'b1, SW, 32'(4*DEPTH), 32'hCAFEF00D);
        access(0, 1'b0, SW, 32'h0, 32'd0);
        access(0, 1'b1, SBU, 32'h4, 32'h000000FF);
        access(0, 1'b0, SW, 32'h4, 32'd0);

        // Reset during WAIT aborts a store
        @(negedge clk);
        drive(0, 1'b1, 1'b1, SW, 32'h20, 32'h12345678);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, SB, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("midop_ready", 32'(ready_a), 32'd0);
        check("midop_rdata", rdata_a, 32'd0);
        last_rd[0] = 32'd0;
        last_rd[1] = 32'd0;
        repeat (4) @(posedge clk);
        access(0, 1'b0, SW, 32'h20, 32'd0);

        // Randomised accesses against the reference model
        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0)
                sz = we ? legal_codes[$urandom_range(0, 2)] : legal_codes[$urandom_range(0, 4)];
            else
                sz = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) addr = 32'(4*DEPTH) + 32'($urandom_range(0, 255));
            else                           addr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                if (sz[1:0] == 2'b01)      addr = addr & ~32'd1;
                else if (sz[1:0] == 2'b10) addr = addr & ~32'd3;
            end
            access(0, we, sz, addr, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Zero-wait instance: seed four words, then hold REQ for four loads
        for (int w = 0; w < 4; w++) access(1, 1'b1, SW, 32'(4*w), $urandom);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, SW, 32'd0, $urandom);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            predict(1, 1'b0, SW, 32'(4*i), 32'd0, f, r);
            e.cyc = cyc; e.fault = f; e.rdata = r;
            q_b.push_back(e);
            drive(1, 1'b1, 1'b0, SW, 32'(4*(i+1)), $urandom);
            @(posedge clk);
            if (i == 3) begin
                #1;
                req_b = 1'b0;
            end
        end

        repeat (8) @(posedge clk);
        @(negedge clk);
        check("drain_a", 32'(q_a.size()), 32'd0);
        check("drain_b", 32'(q_b.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's load/store port: accepts a byte-addressed access request (address, write data, size code, write enable), inserts a parameterised number of wait states, and completes with a one-cycle READY pulse carrying registered, sign- or zero-extended read data. It sits between the datapath's DATA_ADDR/WRITE_DATA/READ_DATA port and a word-organised little-endian storage array. It also reports misaligned, out-of-range or illegal-size accesses through FAULT.

## Interface
- DEPTH_WORDS, 1024 — storage depth in 32-bit words; power of two.
- WAIT_STATES, 2 — cycles spent in WAIT before the response; 0 to 15.
- CLK  input  1  — single clock; all state changes on the rising edge.
- RST  input  1  — synchronous reset, active-low (reset when RST=0 at a rising edge).
- REQ  input  1  — access request; sampled only in IDLE.
- WE  input  1  — 1 = store, 0 = load; captured with REQ.
- SIZE  input  3  — funct3 code: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- ADDR  input  32  — byte address; captured with REQ.
- WDATA  input  32  — store data, right-aligned; captured with REQ.
- RDATA  output  32  — load result; registered.
- READY  output  1  — one-cycle completion pulse.
- FAULT  output  1  — error flag; valid only while READY=1.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: REQ=1 captures WE, SIZE, ADDR and WDATA. If WAIT_STATES>0, the next state is WAIT with the counter loaded to WAIT_STATES-1. Otherwise the next state is RESP.
- WAIT: decrement the counter. When the counter is 0, go to RESP.
- RESP: READY=1 for exactly one cycle, then return to IDLE unconditionally.
- REQ is ignored in WAIT and RESP. The requester holds nothing after the capture edge.
- Fault conditions, evaluated on the captured request:
  - Misaligned: half access with ADDR[0]=1, or word access with ADDR[1:0]≠0.
  - Out of range: ADDR[31:2] ≥ DEPTH_WORDS.
  - Illegal size: load SIZE not in {000,001,010,100,101}; store SIZE not in {000,001,010}.
- A faulting access completes with the same latency and FAULT=1. A faulting store leaves memory unmodified. A faulting load returns RDATA=0.
- Store commit:
  - The store is written on the edge that enters RESP.
  - Byte enables come from SIZE and ADDR[1:0]: byte → lane ADDR[1:0]; half → lanes {ADDR[1],0}+{0,1}; word → all lanes.
  - Source data is WDATA[7:0] for byte, WDATA[15:0] for half, full WDATA for word.
  - RDATA is not updated by a store.
- Load:
  - The addressed word is read and lane-selected; the result is sign-extended for 000/001 and zero-extended for 100/101.
  - The result is registered into RDATA on the edge entering RESP.
  - RDATA holds its value until the next load completion.
- Storage contents are not initialised or cleared by reset.

## Timing
- Capture edge E0 is the IDLE edge with REQ=1. READY is high during cycle E0+1+WAIT_STATES. Default latency is 3 cycles.
- Minimum request spacing is WAIT_STATES+2 cycles. The earliest next capture is the edge at the end of the RESP cycle, while the FSM is back in IDLE.
- A load immediately after a store to the same word returns the new data, because the store has committed before the load is captured.
- Reset values: state=IDLE, counter=0, READY=0, FAULT=0, RDATA=0.
- Reset asserted in WAIT aborts the access with no READY and no memory write.
- Reset asserted on the RESP edge suppresses READY. A store already committed on entry to RESP stays committed.
- REQ held high continuously produces back-to-back accesses at the minimum spacing.

## Structure
- Shared package mem_pkg holds:
  - size codes SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU;
  - the state enum {IDLE, WAIT, RESP};
  - the fault-check function.
- One sub-module, load_extend. It is combinational: inputs are the 32-bit word, ADDR[1:0] and SIZE; output is the 32-bit extended result. The top level instantiates it once.
- The storage is an inferred array reg [31:0] mem [0:DEPTH_WORDS-1] with per-lane write enables.

## Test plan
- Word store then load, WAIT_STATES=2: store 0xDEADBEEF at 0x10, then load word at 0x10 → READY at E0+3, RDATA=0xDEADBEEF, FAULT=0.
- Byte lanes and extension after that store:
  - lb 0x13 → 0xFFFFFFDE
  - lbu 0x13 → 0x000000DE
  - lh 0x10 → 0xFFFFBEEF
  - lhu 0x12 → 0x0000DEAD
- Partial store: sb 0x55 at 0x11, then lw 0x10 → 0xDEAD55EF. Other lanes are unchanged.
- Faults:
  - lw at 0x12 → FAULT=1, RDATA=0.
  - sw at byte 4·DEPTH_WORDS → FAULT=1; a following lw 0x0 shows memory unchanged.
  - Store with SIZE=100 → FAULT=1.
- Reset mid-op: sw 0x12345678 at 0x20 with RST=0 during WAIT → no READY; after reset, lw 0x20 returns the prior contents.
- Throughput: REQ held high for 4 loads with WAIT_STATES=0 → READY pulses every 2 cycles; also confirm REQ asserted during RESP is not double-captured.
